mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined CPU.
//  Sits in EX beside the ALU and takes rs/rt operands read and forwarded from the register file.
//  HI/LO feed MFHI/MFLO results back to writeback, and on to the register-file write port.
//  Busy drives the hazard unit: any MDU instruction in ID stalls while busy=1.
// PARAMETERS
//  MUL_CYCLES  5   cycles from accepted MULT/MULTU to HI/LO update (>=1)
//  DIV_CYCLES  10  cycles from accepted DIV/DIVU to HI/LO update (>=1)
// PORTS
//  clk      in   1   clock, all state updates on rising edge
//  reset    in   1   synchronous, active-high
//  start    in   1   op/src_a/src_b valid this cycle
//  op       in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op)
//  src_a    in   32  rs operand (dividend / multiplicand / MT data)
//  src_b    in   32  rt operand (divisor / multiplier)
//  busy     out  1   operation in flight; HI/LO not yet final
//  hi       out  32  HI register (registered)
//  lo       out  32  LO register (registered)
// BEHAVIOUR
//  - Reset: busy=0, hi=0, lo=0, counter=0, pending result discarded. This holds even mid-operation.
//  - Accept: a start with busy=0 is accepted at the edge. A start with busy=1 is ignored;
//    the hazard unit must stall, and ignoring it is never an error.
//  - MULT/MULTU accepted at edge T0:
//    - The 64-bit product is captured into a pending register at T0; busy=1 from T0.
//    - At edge T0+MUL_CYCLES: {hi,lo} <= product and busy <= 0.
//    - busy is therefore high for exactly MUL_CYCLES cycles.
//  - DIV/DIVU: same timing with DIV_CYCLES. lo <= quotient, hi <= remainder.
//    - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
//    - Divide by zero (either signedness): lo <= 32'hFFFF_FFFF, hi <= src_a.
//    - Signed overflow (0x8000_0000 / -1): lo <= 32'h8000_0000, hi <= 0.
//  - Signed vs unsigned: MULT/DIV treat operands as two's complement; MULTU/DIVU as unsigned.
//  - MTHI/MTLO accepted at edge T0: hi (or lo) <= src_a at T0. busy stays 0 (zero latency).
//    - They are ignored while busy=1.
//  - Reserved op with start: no state change, busy stays 0.
//  - Operands are sampled only at acceptance; later changes to src_a/src_b are don't-care.
//  - hi/lo hold their old values for the whole busy window and change only at the completion edge.
//  - Counter: loaded with N-1 at accept, decrements while busy. Completion fires when it is 0 and busy=1.
//    - Width is $clog2(max(MUL_CYCLES,DIV_CYCLES))+1, so it never wraps.
//  - Back-to-back: a start in the cycle busy falls (the first cycle with busy=0) is accepted normally.
//    - That gives zero bubbles after completion.
//  - Arithmetic is modelled behaviourally (* and /) on captured operands. Latency comes from the counter only.
// TESTING
//  1. Reset:
//     - Assert reset 2 cycles -> busy=0, hi=0, lo=0.
//     - MTHI 0x1234 during reset -> hi stays 0.
//  2. MULT:
//     - MULT a=-3 (0xFFFF_FFFD), b=7 -> busy=1 for 5 cycles.
//     - Then hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
//     - MULTU of the same operands -> hi=0x0000_0006, lo=0xFFFF_FFEB.
//  3. DIV:
//     - DIV a=-7, b=2 -> after 10 busy cycles lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
//     - DIVU 7/2 -> lo=3, hi=1.
//  4. Boundary:
//     - DIVU 5/0 -> lo=0xFFFF_FFFF, hi=5.
//     - DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
//  5. Busy ignore:
//     - Issue MTLO 0xAA and a second MULT during DIV busy -> both ignored.
//     - Only the DIV result appears; busy length is unchanged at 10.
//  6. Reset mid-op and back-to-back:
//     - Reset at cycle 3 of a MULT -> busy=0, hi=lo=0, and no late update.
//     - MULT then MTHI 0x55 in the first busy=0 cycle -> hi=0x55 next edge, lo keeps the product.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at acceptance and committed after a fixed per-operation latency.
module mult_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [63:0]        pending, pending_next;
  logic [31:0]        hi_next, lo_next;

  // Datapath: all four results are formed from the live operands; only the
  // selected one is captured into pending on acceptance.
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, div_b_safe, sdiv_b_safe;
  logic [31:0] uq, ur, sq_mag, sr_mag, sq, sr;
  logic        div_zero;

  always_comb begin
    div_zero    = (src_b == 32'd0);
    prod_s      = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u      = {32'd0, src_a} * {32'd0, src_b};
    // Signed division runs on magnitudes so 0x8000_0000 / -1 needs no special
    // case: the unsigned quotient 0x8000_0000 is already the required result.
    mag_a       = src_a[31] ? (32'd0 - src_a) : src_a;
    mag_b       = src_b[31] ? (32'd0 - src_b) : src_b;
    div_b_safe  = div_zero ? 32'd1 : src_b;
    sdiv_b_safe = div_zero ? 32'd1 : mag_b;
    uq          = src_a / div_b_safe;
    ur          = src_a % div_b_safe;
    sq_mag      = mag_a / sdiv_b_safe;
    sr_mag      = mag_a % sdiv_b_safe;
    sq          = (src_a[31] ^ src_b[31]) ? (32'd0 - sq_mag) : sq_mag;
    sr          = src_a[31] ? (32'd0 - sr_mag) : sr_mag;
  end

  assign busy = (state == S_BUSY);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pending_next = pending;
    hi_next      = hi;
    lo_next      = lo;

    if (state == S_BUSY) begin
      if (cnt == '0) begin
        {hi_next, lo_next} = pending;
        state_next         = S_IDLE;
      end else begin
        cnt_next = cnt - CNT_W'(1);
      end
    end else if (start) begin
      case (op_e'(op))
        OP_MULT: begin
          pending_next = prod_s;
          cnt_next     = CNT_W'(MUL_CYCLES - 1);
          state_next   = S_BUSY;
        end
        OP_MULTU: begin
          pending_next = prod_u;
          cnt_next     = CNT_W'(MUL_CYCLES - 1);
          state_next   = S_BUSY;
        end
        OP_DIV: begin
          pending_next = div_zero ? {src_a, 32'hFFFF_FFFF} : {sr, sq};
          cnt_next     = CNT_W'(DIV_CYCLES - 1);
          state_next   = S_BUSY;
        end
        OP_DIVU: begin
          pending_next = div_zero ? {src_a, 32'hFFFF_FFFF} : {ur, uq};
          cnt_next     = CNT_W'(DIV_CYCLES - 1);
          state_next   = S_BUSY;
        end
        OP_MTHI: hi_next = src_a;
        OP_MTLO: lo_next = src_a;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pending <= pending_next;
      hi      <= hi_next;
      lo      <= lo_next;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO and busy length are queued
// at issue and compared when the unit goes idle.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference results computed in 64-bit arithmetic, independent of the RTL datapath.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (o)
      3'd0: res = 64'(sa * sb_);
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb_;
          r = sa % sb_;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {ub[63:0] == 0 ? 32'd0 : 32'(ua % ub), 32'(ua / ub)};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Called at a negedge; drives one accepted op and returns at the next negedge.
  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int ec);
    exp_t e;
    e.name = name; e.hi = eh; e.lo = el; e.cycles = ec;
    sb.push_back(e);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; src_a = $urandom; src_b = $urandom;
  endtask

  // Counts busy cycles (bounded) and flags any HI/LO movement inside the busy window.
  task automatic wait_idle(output int cycles, output bit changed);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    cycles = 0; changed = 1'b0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
      if (busy === 1'b1 && (hi !== h0 || lo !== l0)) changed = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 3'd4; src_a = 32'h1234;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic run_table(input string tag, input logic [2:0] ops[], input logic [31:0] as[],
                           input logic [31:0] bs[], input logic [31:0] ehs[], input logic [31:0] els[]);
    int cyc; bit chg; exp_t e;
    for (int i = 0; i < ops.size(); i++) begin
      issue($sformatf("%s%0d", tag, i), ops[i], as[i], bs[i], ehs[i], els[i], (ops[i] < 3'd2) ? 5 : 10);
      wait_idle(cyc, chg);
      e = sb.pop_front();
      checks++;
      if ({hi, lo} !== {e.hi, e.lo} || cyc != e.cycles || chg) begin
        errors++;
        $display("FAIL %s: got hi=%h lo=%h cycles=%0d moved=%0b want hi=%h lo=%h cycles=%0d moved=0",
                 e.name, hi, lo, cyc, chg, e.hi, e.lo, e.cycles);
      end
    end
  endtask

  task automatic test_mult();
    run_table("mult", '{3'd0, 3'd1, 3'd0, 3'd1},
              '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF},
              '{32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF},
              '{32'hFFFF_FFFF, 32'h0000_0006, 32'h4000_0000, 32'hFFFF_FFFE},
              '{32'hFFFF_FFEB, 32'hFFFF_FFEB, 32'h0000_0000, 32'h0000_0001});
  endtask

  task automatic test_div();
    run_table("div", '{3'd2, 3'd3, 3'd2},
              '{32'hFFFF_FFF9, 32'd7, 32'd7},
              '{32'd2, 32'd2, 32'hFFFF_FFFE},
              '{32'hFFFF_FFFF, 32'd1, 32'd1},
              '{32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFD});
  endtask

  task automatic test_boundary();
    run_table("bound", '{3'd3, 3'd2, 3'd2},
              '{32'd5, 32'h8000_0000, 32'hFFFF_FFF7},
              '{32'd0, 32'hFFFF_FFFF, 32'd0},
              '{32'd5, 32'd0, 32'hFFFF_FFF7},
              '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF});
  endtask

  task automatic test_busy_ignore();
    int cyc; exp_t e; logic [31:0] h0, l0; bit chg;
    issue("busy_ignore", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    h0 = hi; l0 = lo; cyc = 0; chg = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      start = 1'b0;
      if (cyc == 3) begin start = 1'b1; op = 3'd5; src_a = 32'hAA; end
      if (cyc == 5) begin start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd3; end
      @(negedge clk);
      start = 1'b0;
      if (busy === 1'b1 && (hi !== h0 || lo !== l0)) chg = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || cyc != e.cycles || chg) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h cycles=%0d moved=%0b want hi=%h lo=%h cycles=%0d moved=0",
               e.name, hi, lo, cyc, chg, e.hi, e.lo, e.cycles);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL busy_ignore_after: got busy=%b hi=%h lo=%h want busy=0 hi=2 lo=e", busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = 3'd0; src_a = 32'd6; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_late: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit chg; exp_t e;
    issue("b2b_mult", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5);
    wait_idle(cyc, chg);
    e = sb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || cyc != e.cycles || chg) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h cycles=%0d want hi=%h lo=%h cycles=%0d", e.name, hi, lo, cyc, e.hi, e.lo, e.cycles);
    end
    start = 1'b1; op = 3'd4; src_a = 32'h55;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h55 || lo !== 32'd42) begin
      errors++;
      $display("FAIL b2b_mthi: got busy=%b hi=%h lo=%h want busy=0 hi=55 lo=2a", busy, hi, lo);
    end
    issue("b2b_first", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 5);
    wait_idle(cyc, chg);
    e = sb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || cyc != e.cycles || chg) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h cycles=%0d want hi=%h lo=%h cycles=%0d", e.name, hi, lo, cyc, e.hi, e.lo, e.cycles);
    end
    issue("b2b_second", 3'd3, 32'd20, 32'd6, 32'd2, 32'd3, 10);
    wait_idle(cyc, chg);
    e = sb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || cyc != e.cycles || chg) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h cycles=%0d want hi=%h lo=%h cycles=%0d", e.name, hi, lo, cyc, e.hi, e.lo, e.cycles);
    end
  endtask

  task automatic test_random();
    logic [31:0] mh, ml, a, b;
    logic [63:0] r;
    logic [2:0] o;
    int cyc; bit chg; exp_t e;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mh = 32'd0; ml = 32'd0;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 5) == 0) b = b & 32'hF;
      if (o < 3'd4) begin
        r = model(o, a, b);
        mh = r[63:32]; ml = r[31:0];
        issue($sformatf("rand%0d_op%0d", i, o), o, a, b, mh, ml, (o < 3'd2) ? 5 : 10);
        wait_idle(cyc, chg);
        e = sb.pop_front();
        checks++;
        if ({hi, lo} !== {e.hi, e.lo} || cyc != e.cycles || chg) begin
          errors++;
          $display("FAIL %s a=%h b=%h: got hi=%h lo=%h cycles=%0d moved=%0b want hi=%h lo=%h cycles=%0d",
                   e.name, a, b, hi, lo, cyc, chg, e.hi, e.lo, e.cycles);
        end
      end else begin
        if (o == 3'd4) mh = a;
        if (o == 3'd5) ml = a;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== mh || lo !== ml) begin
          errors++;
          $display("FAIL rand%0d_op%0d: got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h", i, o, busy, hi, lo, mh, ml);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_boundary();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
